block_stream_gen: RTL and testbench
===================================

BLOCK_STREAM_GEN -- requirements
Module: block_stream_gen

Interface
REQ-001 clk  input  1  single system clock; all state updates on the rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-003 cmd_valid  input  1  word command offered this cycle.
REQ-004 cmd  input  2  word select: 00 = "begin", 01 = "end", 10 = "a", 11 = separator only (no word characters).
REQ-005 case_mask  input  5  per-character uppercase select; bit i = 1 emits character i of the word in upper case; unused bits are ignored.
REQ-006 cmd_ready  output  1  block can accept a command this cycle.
REQ-007 out  output  8  ASCII character stream, one character per cycle.
REQ-008 out_valid  output  1  out carries a valid character.
REQ-009 depth  output  4  count of currently unmatched "begin" words.
REQ-010 balanced  output  1  golden expected checker result: 1 when depth == 0 and no unmatched "end" has ever been emitted.

Function
REQ-011 A command SHALL be accepted only in a cycle where cmd_valid = 1 and cmd_ready = 1.
REQ-012 cmd_ready SHALL be 1 only in state IDLE; it SHALL be registered, with no combinational path from cmd_valid.
REQ-013 States SHALL be IDLE, CHAR and SPACE:
- IDLE -> CHAR on acceptance of cmd 00, 01 or 10.
- IDLE -> SPACE on acceptance of cmd 11.
- CHAR -> SPACE after the last character of the word.
- SPACE -> IDLE unconditionally.
REQ-014 The first character of an accepted word SHALL appear on out with out_valid = 1 in the cycle after acceptance.
REQ-015 Each following character SHALL appear in each following cycle, with no gaps.
REQ-016 Word lengths SHALL be: "begin" = 5 cycles, "end" = 3 cycles, "a" = 1 cycle; a character index counter (0..4) SHALL select the character.
REQ-017 Case SHALL be applied by clearing bit 5 of the lowercase ASCII code when case_mask[index] = 1; case_mask SHALL be captured at acceptance and held stable for the whole word.
REQ-018 SPACE SHALL emit 8'h20 with out_valid = 1 for exactly one cycle.
REQ-019 Total occupancy per command SHALL be: begin 6 cycles, end 4 cycles, "a" 2 cycles, separator 1 cycle.
REQ-020 Back-to-back commands SHALL reach a throughput of one new command per (occupancy + 1) cycles, accounting for the IDLE acceptance cycle.
REQ-021 In IDLE, out SHALL be 8'h00 and out_valid SHALL be 0.
REQ-022 depth and the sticky error flag SHALL update in the cycle the word's trailing space is emitted, not at acceptance.
REQ-023 On a "begin" word, depth SHALL increment, saturating at 15; an increment attempted at 15 SHALL set the error flag.
REQ-024 On an "end" word with depth > 0, depth SHALL decrement.
REQ-025 On an "end" word with depth == 0, depth SHALL stay at 0 and the error flag SHALL set and remain set until reset.
REQ-026 "a" words and separators SHALL NOT change depth or the error flag.
REQ-027 balanced SHALL be registered and equal (depth == 0) AND NOT error, as of the last update.
REQ-028 cmd_valid asserted outside IDLE SHALL be ignored; the command SHALL be neither queued nor lost-flagged.

Reset
REQ-029 Asserting reset (0) SHALL immediately, without waiting for a clock edge, set:
- state = IDLE, index = 0;
- out = 8'h00, out_valid = 0, cmd_ready = 1;
- depth = 0, error = 0, balanced = 1.
REQ-030 Reset asserted mid-word SHALL abort the word; no trailing space SHALL be emitted and depth SHALL NOT be updated for that word.
REQ-031 Command acceptance SHALL begin on the first rising edge after reset deasserts.

Structure
REQ-032 Package block_pkg SHALL hold:
- the cmd encodings (CMD_BEGIN, CMD_END, CMD_A, CMD_SEP);
- the state enumeration;
- the ASCII constants (space 8'h20, case bit 5);
- the depth width constant (4).
REQ-033 A combinational sub-module block_word_rom SHALL map (cmd, index) to the lowercase character and a last-character flag.
REQ-034 The FSM, counters and depth tracking SHALL stay in block_stream_gen.

Verification
REQ-035 Single command cmd = 00, case_mask = 5'b00100 after reset -> out = "b","e","G","i","n"," " on 6 consecutive cycles; then depth = 1, balanced = 0.
REQ-036 Sequence begin, end (case_mask = 5'b00010), then end -> second word emits "e","N","d"," " and gives depth = 0, balanced = 1; third word leaves depth = 0, error set, balanced = 0, persisting through a later begin/end pair.
REQ-037 cmd_valid held at 1 with cmd = 01 continuously -> exactly one acceptance per 5 cycles; cmd_ready = 0 for 4 cycles after each acceptance.
REQ-038 16 consecutive begins -> depth saturates at 15, error = 1, balanced = 0.
REQ-039 Reset pulsed during the 3rd character of "begin" -> out = 8'h00 and out_valid = 0 immediately; depth = 0; next accepted "a" emits "a"," ".
REQ-040 Separator command (cmd = 11) in IDLE -> single 8'h20 on the next cycle; depth and balanced unchanged.

Source files
------------

// File: rtl/block_pkg.sv
//------------------------------------------------------------------------------
// Module   : block_pkg
// Purpose  : Shared encodings, states and constants for the block word stream.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package block_pkg;

  localparam logic [1:0] CMD_BEGIN = 2'b00;
  localparam logic [1:0] CMD_END   = 2'b01;
  localparam logic [1:0] CMD_A     = 2'b10;
  localparam logic [1:0] CMD_SEP   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHAR  = 2'd1,
    ST_SPACE = 2'd2
  } state_t;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam int         CASE_BIT    = 5;

  localparam int DEPTH_W = 4;
  localparam int INDEX_W = 3;
  localparam int MASK_W  = 5;

  localparam logic [DEPTH_W-1:0] DEPTH_ZERO = '0;
  localparam logic [DEPTH_W-1:0] DEPTH_ONE  = {{(DEPTH_W-1){1'b0}}, 1'b1};
  localparam logic [DEPTH_W-1:0] DEPTH_MAX  = {DEPTH_W{1'b1}};

endpackage

`default_nettype wire

// File: rtl/block_word_rom.sv
//------------------------------------------------------------------------------
// Module   : block_word_rom
// Purpose  : Maps (word, character index) to a lowercase ASCII code and a
//            last-character flag.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module block_word_rom
  import block_pkg::*;
(
  input  logic [1:0]         cmd,
  input  logic [INDEX_W-1:0] index,
  output logic [7:0]         ch,
  output logic               last
);

  always_comb begin
    ch   = 8'h00;
    last = 1'b1;
    case (cmd)
      CMD_BEGIN: begin
        last = (index == 3'd4);
        case (index)
          3'd0:    ch = "b";
          3'd1:    ch = "e";
          3'd2:    ch = "g";
          3'd3:    ch = "i";
          3'd4:    ch = "n";
          default: ch = 8'h00;
        endcase
      end
      CMD_END: begin
        last = (index == 3'd2);
        case (index)
          3'd0:    ch = "e";
          3'd1:    ch = "n";
          3'd2:    ch = "d";
          default: ch = 8'h00;
        endcase
      end
      CMD_A: begin
        last = (index == 3'd0);
        ch   = (index == 3'd0) ? 8'h61 : 8'h00;
      end
      default: begin
        last = 1'b1;
        ch   = 8'h00;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/block_stream_gen.sv
//------------------------------------------------------------------------------
// Module   : block_stream_gen
// Purpose  : Emits begin/end/a words as an ASCII stream, one character per
//            cycle, and tracks begin/end nesting depth and balance.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module block_stream_gen
  import block_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  input  logic [1:0]         cmd,
  input  logic [MASK_W-1:0]  case_mask,
  output logic               cmd_ready,
  output logic [7:0]         out,
  output logic               out_valid,
  output logic [DEPTH_W-1:0] depth,
  output logic               balanced
);

  state_t               r_state;
  state_t               w_state_next;
  logic [INDEX_W-1:0]   r_index;
  logic [INDEX_W-1:0]   w_index_next;
  logic [1:0]           r_cmd;
  logic [MASK_W-1:0]    r_mask;
  logic                 r_cmd_ready;
  logic [DEPTH_W-1:0]   r_depth;
  logic                 r_error;
  logic                 r_balanced;

  logic                 w_accept;
  logic [7:0]           w_char;
  logic [7:0]           w_char_cased;
  logic                 w_last;
  logic [MASK_W-1:0]    w_sel;
  logic                 w_upper;

  assign w_accept = cmd_valid & r_cmd_ready;

  block_word_rom u_rom (
    .cmd   (r_cmd),
    .index (r_index),
    .ch    (w_char),
    .last  (w_last)
  );

  assign w_sel   = {{(MASK_W-1){1'b0}}, 1'b1} << r_index;
  assign w_upper = |(r_mask & w_sel);

  always_comb begin
    w_char_cased = w_char;
    if (w_upper) begin
      w_char_cased[CASE_BIT] = 1'b0;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_index_next = r_index;
    out          = 8'h00;
    out_valid    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_index_next = '0;
          w_state_next = (cmd == CMD_SEP) ? ST_SPACE : ST_CHAR;
        end
      end
      ST_CHAR: begin
        out       = w_char_cased;
        out_valid = 1'b1;
        if (w_last) begin
          w_index_next = '0;
          w_state_next = ST_SPACE;
        end else begin
          w_index_next = r_index + 3'd1;
        end
      end
      ST_SPACE: begin
        out          = ASCII_SPACE;
        out_valid    = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_index_next = '0;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Ready is a flop fed from next-state, so it never depends on cmd_valid in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_index     <= '0;
      r_cmd_ready <= 1'b1;
    end else begin
      r_state     <= w_state_next;
      r_index     <= w_index_next;
      r_cmd_ready <= (w_state_next == ST_IDLE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cmd  <= CMD_SEP;
      r_mask <= '0;
    end else if (w_accept) begin
      r_cmd  <= cmd;
      r_mask <= case_mask;
    end
  end

  // Nesting bookkeeping commits only when the trailing space goes out, so an aborted word leaves no trace.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_depth    <= DEPTH_ZERO;
      r_error    <= 1'b0;
      r_balanced <= 1'b1;
    end else if (r_state == ST_SPACE) begin
      case (r_cmd)
        CMD_BEGIN: begin
          r_balanced <= 1'b0;
          if (r_depth == DEPTH_MAX) begin
            r_error <= 1'b1;
          end else begin
            r_depth <= r_depth + DEPTH_ONE;
          end
        end
        CMD_END: begin
          if (r_depth == DEPTH_ZERO) begin
            r_error    <= 1'b1;
            r_balanced <= 1'b0;
          end else begin
            r_depth    <= r_depth - DEPTH_ONE;
            r_balanced <= (r_depth == DEPTH_ONE) && !r_error;
          end
        end
        default: begin
          r_depth <= r_depth;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign depth     = r_depth;
  assign balanced  = r_balanced;

endmodule

`default_nettype wire

// File: tb/tb_block_stream_gen.sv
//------------------------------------------------------------------------------
// Module   : tb_block_stream_gen
// Purpose  : Scoreboard bench for block_stream_gen with directed word vectors.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_block_stream_gen;
  import block_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic [4:0] case_mask = 5'b00000;
  logic       cmd_ready;
  logic [7:0] out;
  logic       out_valid;
  logic [3:0] depth;
  logic       balanced;

  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  always #5 clk = ~clk;

  block_stream_gen dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .case_mask (case_mask),
    .cmd_ready (cmd_ready),
    .out       (out),
    .out_valid (out_valid),
    .depth     (depth),
    .balanced  (balanced)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every valid character must be the next one the stimulus queued.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_char: got %0h expected none at %0t", out, $time);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("out_char", {24'h0, out}, {24'h0, mon_exp});
        end
      end else begin
        chk("idle_out", {23'h0, out_valid, out}, 32'h0);
      end
    end
  end

  task automatic send(input logic [1:0] c, input logic [4:0] m, input string s);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (cmd_ready !== 1'b1) begin
      chk("send_ready_timeout", {31'h0, cmd_ready}, 32'h1);
      return;
    end
    cmd_valid = 1'b1;
    cmd       = c;
    case_mask = m;
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    case_mask = ~m;
    cmd       = ~c;
  endtask

  task automatic wait_idle();
    int  n = 0;
    logic ok;
    do begin
      @(negedge clk);
      n++;
      ok = (cmd_ready === 1'b1) && (exp_q.size() == 0);
    end while (!ok && n < 200);
    chk("idle_reached", {31'h0, ok}, 32'h1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int acc_cnt;
    int last_acc;

    // Asynchronous reset, checked before any clock edge
    #2 reset = 1'b0;
    #1;
    chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    chk("rst_out", {24'h0, out}, 32'h0);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_depth", {28'h0, depth}, 32'h0);
    chk("rst_balanced", {31'h0, balanced}, 32'h1);
    @(negedge clk);
    #2 reset = 1'b1;

    // Single begin with one uppercase character
    send(CMD_BEGIN, 5'b00100, "beGin ");
    wait_idle();
    chk("begin_depth", {28'h0, depth}, 32'd1);
    chk("begin_balanced", {31'h0, balanced}, 32'h0);

    // Matching end, then an unmatched end, then a pair
    send(CMD_END, 5'b00010, "eNd ");
    wait_idle();
    chk("end_depth", {28'h0, depth}, 32'd0);
    chk("end_balanced", {31'h0, balanced}, 32'h1);
    send(CMD_END, 5'b00000, "end ");
    wait_idle();
    chk("unmatched_depth", {28'h0, depth}, 32'd0);
    chk("unmatched_balanced", {31'h0, balanced}, 32'h0);
    send(CMD_BEGIN, 5'b11111, "BEGIN ");
    send(CMD_END, 5'b00101, "EnD ");
    wait_idle();
    chk("sticky_depth", {28'h0, depth}, 32'd0);
    chk("sticky_balanced", {31'h0, balanced}, 32'h0);

    // cmd_valid held high with end: one acceptance every 5 cycles
    do_reset();
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd       = CMD_END;
    case_mask = 5'b00000;
    acc_cnt   = 0;
    last_acc  = -1;
    for (int c = 0; c < 20; c++) begin
      if (cmd_ready === 1'b1) begin
        for (int i = 0; i < 4; i++) exp_q.push_back((i == 0) ? 8'h65 : (i == 1) ? 8'h6E : (i == 2) ? 8'h64 : 8'h20);
        if (last_acc >= 0) chk("accept_interval", c - last_acc, 32'd5);
        last_acc = c;
        acc_cnt++;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("accept_count", acc_cnt, 32'd4);
    wait_idle();

    // Sixteen begins saturate depth at 15 and raise the error
    do_reset();
    for (int k = 0; k < 15; k++) send(CMD_BEGIN, 5'b00000, "begin ");
    wait_idle();
    chk("depth_15", {28'h0, depth}, 32'd15);
    send(CMD_BEGIN, 5'b00001, "Begin ");
    wait_idle();
    chk("sat_depth", {28'h0, depth}, 32'd15);
    chk("sat_balanced", {31'h0, balanced}, 32'h0);
    send(CMD_END, 5'b00000, "end ");
    wait_idle();
    chk("sat_then_end_depth", {28'h0, depth}, 32'd14);
    chk("sat_then_end_balanced", {31'h0, balanced}, 32'h0);

    // Reset during the third character of begin
    send(CMD_BEGIN, 5'b00000, "beg");
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_out", {24'h0, out}, 32'h0);
    chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("midrst_depth", {28'h0, depth}, 32'd0);
    chk("midrst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    chk("midrst_balanced", {31'h0, balanced}, 32'h1);
    @(negedge clk);
    #2 reset = 1'b1;
    chk("midrst_drained", exp_q.size(), 32'd0);
    send(CMD_A, 5'b00000, "a ");
    wait_idle();
    chk("a_depth", {28'h0, depth}, 32'd0);
    chk("a_balanced", {31'h0, balanced}, 32'h1);

    // Separator leaves depth and balance untouched
    send(CMD_A, 5'b00001, "A ");
    send(CMD_BEGIN, 5'b10000, "begiN ");
    send(CMD_SEP, 5'b11111, " ");
    wait_idle();
    chk("sep_depth", {28'h0, depth}, 32'd1);
    chk("sep_balanced", {31'h0, balanced}, 32'h0);

    chk("final_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
